rsa_stream_packer: RTL and testbench

Upstream feeder for `en_decoder_RSA`. Accepts a symbol stream over a valid/ready handshake and packs it MSB-first into one 1023-bit frame. Plaintext symbols are 7-bit ASCII; ciphertext symbols are 14-bit. Each completed frame is presented on `frame_out` and held until the consumer accepts it. The block replaces file-based loading of `in_stream` with a synthesizable path.

---
 rtl/rsa_stream_packer_if.sv | 27 ++
 rtl/rsa_stream_packer.sv | 97 +++++++++
 tb/tb_rsa_stream_packer.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rsa_stream_packer_if.sv
// Symbol-in / frame-out bus between the stream source, the packer and the RSA engine.
// The slave modport is the packer side, the master modport is the source/consumer side.
interface rsa_stream_packer_if #(
    parameter int FRAME_W = 1023
);
    logic               mode;
    logic               in_valid;
    logic               in_ready;
    logic [13:0]        in_data;
    logic               in_last;
    logic [FRAME_W-1:0] frame_out;
    logic               frame_valid;
    logic               frame_ready;
    logic               frame_mode;
    logic [7:0]         sym_count;
    logic               range_err;

    modport slave (
        input  mode, in_valid, in_data, in_last, frame_ready,
        output in_ready, frame_out, frame_valid, frame_mode, sym_count, range_err
    );

    modport master (
        output mode, in_valid, in_data, in_last, frame_ready,
        input  in_ready, frame_out, frame_valid, frame_mode, sym_count, range_err
    );
endinterface

// File: rtl/rsa_stream_packer.sv
// Packs 7-bit plaintext or 14-bit ciphertext symbols MSB-first into one 1023-bit
// frame for en_decoder_RSA and holds the frame until the consumer takes it.
//
// state  | meaning
// S_FILL | accepting symbols into the current frame
// S_HOLD | frame complete, frame_out held until frame_ready
module rsa_stream_packer #(
    parameter int N       = 10573,
    parameter int FRAME_W = 1023
) (
    input  logic               clk,
    input  logic               rst,
    rsa_stream_packer_if.slave bus
);
    typedef enum logic {S_FILL, S_HOLD} state_t;

    localparam logic [13:0] N_LIM = 14'(N);

    state_t             r_state;
    logic [FRAME_W-1:0] r_frame;
    logic               r_valid;
    logic               r_fmode;
    logic               r_mlat;
    logic [7:0]         r_cnt;
    logic               r_rerr;

    logic               w_accept;
    logic               w_wide;
    logic [7:0]         w_cap;
    logic [7:0]         w_cnt_nxt;
    logic [9:0]         w_shift;
    logic [FRAME_W-1:0] w_top;
    logic [FRAME_W-1:0] w_ins;
    logic               w_close;

    assign bus.in_ready = (r_state == S_FILL) && !rst;
    assign w_accept     = bus.in_valid && bus.in_ready;

    // Until the first symbol is taken, the live mode input decides the symbol width.
    assign w_wide    = r_mlat ? r_fmode : bus.mode;
    assign w_cap     = w_wide ? 8'd73 : 8'd146;
    assign w_cnt_nxt = r_cnt + 8'd1;
    assign w_shift   = w_wide ? (10'(r_cnt) * 10'd14) : (10'(r_cnt) * 10'd7);
    assign w_top     = w_wide ? (FRAME_W'(bus.in_data) << (FRAME_W - 14))
                              : (FRAME_W'(bus.in_data[6:0]) << (FRAME_W - 7));
    assign w_ins     = w_top >> w_shift;
    assign w_close   = bus.in_last || (w_cnt_nxt == w_cap);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FILL;
            r_frame <= '0;
            r_valid <= 1'b0;
            r_fmode <= 1'b0;
            r_mlat  <= 1'b0;
            r_cnt   <= 8'd0;
            r_rerr  <= 1'b0;
        end else begin
            case (r_state)
                S_FILL: begin
                    if (w_accept) begin
                        if (!r_mlat) begin
                            r_fmode <= bus.mode;
                            r_mlat  <= 1'b1;
                        end
                        r_frame <= r_frame | w_ins;
                        r_cnt   <= w_cnt_nxt;
                        if (w_wide && (bus.in_data >= N_LIM)) begin
                            r_rerr <= 1'b1;
                        end
                        if (w_close) begin
                            r_state <= S_HOLD;
                            r_valid <= 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    if (bus.frame_ready) begin
                        r_state <= S_FILL;
                        r_valid <= 1'b0;
                        r_frame <= '0;
                        r_cnt   <= 8'd0;
                        r_rerr  <= 1'b0;
                        r_mlat  <= 1'b0;
                    end
                end
                default: r_state <= S_FILL;
            endcase
        end
    end

    assign bus.frame_out   = r_frame;
    assign bus.frame_valid = r_valid;
    assign bus.frame_mode  = r_fmode;
    assign bus.sym_count   = r_cnt;
    assign bus.range_err   = r_rerr;
endmodule

// File: tb/tb_rsa_stream_packer.sv
// Directed bench for rsa_stream_packer: one task per scenario, expected frames
// built from hand-computed symbol values.
module tb_rsa_stream_packer;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    rsa_stream_packer_if #(.FRAME_W(1023)) bus ();

    rsa_stream_packer #(.N(10573), .FRAME_W(1023)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One symbol offered for exactly one cycle; outputs sampled 1 time unit after the edge.
    task automatic send(input logic [13:0] d, input logic l);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = l;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic release_frame();
        @(negedge clk);
        bus.frame_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.frame_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %0b want 0", bus.in_ready); end
        checks++;
        if (bus.frame_out !== 1023'd0 || bus.frame_valid !== 1'b0 || bus.frame_mode !== 1'b0 ||
            bus.sym_count !== 8'd0 || bus.range_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got valid=%0b mode=%0b cnt=%0d err=%0b want all 0",
                     bus.frame_valid, bus.frame_mode, bus.sym_count, bus.range_err);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got %0b want 1", bus.in_ready); end
    endtask

    task automatic test_encrypt();
        logic [1022:0] exp;
        exp = {7'h48, 7'h69, 1009'd0};
        bus.mode = 1'b0;
        send(14'h0048, 1'b0);
        checks++;
        if (bus.frame_valid !== 1'b0 || bus.sym_count !== 8'd1) begin
            errors++; $display("FAIL enc_first got valid=%0b cnt=%0d want 0 1", bus.frame_valid, bus.sym_count);
        end
        send(14'h3F69, 1'b1);
        checks++;
        if (bus.frame_out !== exp) begin
            errors++; $display("FAIL enc_frame got top=%h want top=%h", bus.frame_out[1022:1009], exp[1022:1009]);
        end
        checks++;
        if (bus.frame_valid !== 1'b1 || bus.sym_count !== 8'd2 || bus.frame_mode !== 1'b0 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL enc_status got valid=%0b cnt=%0d mode=%0b rdy=%0b want 1 2 0 0",
                     bus.frame_valid, bus.sym_count, bus.frame_mode, bus.in_ready);
        end
        release_frame();
        checks++;
        if (bus.frame_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.frame_out !== 1023'd0 || bus.sym_count !== 8'd0) begin
            errors++;
            $display("FAIL enc_release got valid=%0b rdy=%0b cnt=%0d want 0 1 0",
                     bus.frame_valid, bus.in_ready, bus.sym_count);
        end
    endtask

    task automatic test_capacity();
        logic [1022:0] exp;
        exp = '0;
        for (int k = 0; k < 146; k++) exp[1022-7*k -: 7] = 7'h41;
        bus.mode = 1'b0;
        for (int k = 0; k < 145; k++) send(14'h0041, 1'b0);
        checks++;
        if (bus.frame_valid !== 1'b0 || bus.sym_count !== 8'd145) begin
            errors++; $display("FAIL cap_145 got valid=%0b cnt=%0d want 0 145", bus.frame_valid, bus.sym_count);
        end
        send(14'h0041, 1'b0);
        checks++;
        if (bus.frame_valid !== 1'b1 || bus.sym_count !== 8'd146 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL cap_close got valid=%0b cnt=%0d rdy=%0b want 1 146 0",
                     bus.frame_valid, bus.sym_count, bus.in_ready);
        end
        checks++;
        if (bus.frame_out !== exp || bus.frame_out[0] !== 1'b0) begin
            errors++; $display("FAIL cap_frame got low=%h bit0=%0b want low=%h bit0=0",
                               bus.frame_out[20:0], bus.frame_out[0], exp[20:0]);
        end
        release_frame();
    endtask

    task automatic test_decrypt();
        logic [1022:0] exp;
        exp = {14'd5000, 14'd10573, 14'd12, 981'd0};
        bus.mode = 1'b1;
        send(14'd5000, 1'b0);
        checks++;
        if (bus.range_err !== 1'b0) begin errors++; $display("FAIL dec_err_early got %0b want 0", bus.range_err); end
        send(14'd10573, 1'b0);
        send(14'd12, 1'b1);
        checks++;
        if (bus.frame_out !== exp) begin
            errors++; $display("FAIL dec_frame got top=%h want top=%h", bus.frame_out[1022:981], exp[1022:981]);
        end
        checks++;
        if (bus.range_err !== 1'b1 || bus.frame_mode !== 1'b1 || bus.sym_count !== 8'd3 || bus.frame_valid !== 1'b1) begin
            errors++;
            $display("FAIL dec_status got err=%0b mode=%0b cnt=%0d valid=%0b want 1 1 3 1",
                     bus.range_err, bus.frame_mode, bus.sym_count, bus.frame_valid);
        end
        release_frame();
        checks++;
        if (bus.range_err !== 1'b0) begin errors++; $display("FAIL dec_err_clear got %0b want 0", bus.range_err); end
    endtask

    task automatic test_backpressure();
        logic [1022:0] exp;
        int bad;
        exp = {7'h55, 1016'd0};
        bus.mode = 1'b0;
        send(14'h0055, 1'b1);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = 14'h0033;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (bus.frame_out !== exp || bus.sym_count !== 8'd1 || bus.in_ready !== 1'b0 || bus.frame_valid !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL bp_hold got %0d unstable cycles want 0", bad); end
        @(negedge clk);
        bus.in_valid    = 1'b0;
        bus.frame_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.frame_ready = 1'b0;
        checks++;
        if (bus.frame_out !== 1023'd0 || bus.in_ready !== 1'b1 || bus.frame_valid !== 1'b0) begin
            errors++; $display("FAIL bp_release got rdy=%0b valid=%0b want 1 0", bus.in_ready, bus.frame_valid);
        end
    endtask

    task automatic test_mode_change();
        logic [1022:0] exp;
        exp = {14'd4660, 14'd341, 14'd9000, 981'd0};
        bus.mode = 1'b1;
        send(14'd4660, 1'b0);
        bus.mode = 1'b0;
        send(14'd341, 1'b0);
        send(14'd9000, 1'b1);
        checks++;
        if (bus.frame_out !== exp) begin
            errors++; $display("FAIL mode_frame got top=%h want top=%h", bus.frame_out[1022:981], exp[1022:981]);
        end
        checks++;
        if (bus.frame_mode !== 1'b1 || bus.sym_count !== 8'd3 || bus.range_err !== 1'b0) begin
            errors++; $display("FAIL mode_status got mode=%0b cnt=%0d err=%0b want 1 3 0",
                               bus.frame_mode, bus.sym_count, bus.range_err);
        end
        release_frame();
    endtask

    task automatic test_reset_mid();
        bus.mode = 1'b1;
        send(14'd100, 1'b0);
        send(14'd11000, 1'b0);
        send(14'd300, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rmid_ready got %0b want 0", bus.in_ready); end
        @(posedge clk);
        #1;
        checks++;
        if (bus.frame_out !== 1023'd0 || bus.sym_count !== 8'd0 || bus.frame_mode !== 1'b0 ||
            bus.range_err !== 1'b0 || bus.frame_valid !== 1'b0) begin
            errors++;
            $display("FAIL rmid_outputs got cnt=%0d mode=%0b err=%0b valid=%0b want 0 0 0 0",
                     bus.sym_count, bus.frame_mode, bus.range_err, bus.frame_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        bus.mode = 1'b0;
        send(14'h007F, 1'b1);
        checks++;
        if (bus.frame_out !== {7'h7F, 1016'd0} || bus.sym_count !== 8'd1 || bus.frame_valid !== 1'b1) begin
            errors++; $display("FAIL rmid_next got top=%h cnt=%0d want top=7f cnt=1",
                               bus.frame_out[1022:1016], bus.sym_count);
        end
        release_frame();
    endtask

    task automatic test_back_to_back();
        // frame_ready held high: frame ready during FILL is ignored, one HOLD cycle per frame.
        bus.mode        = 1'b0;
        bus.frame_ready = 1'b1;
        send(14'h0011, 1'b0);
        checks++;
        if (bus.sym_count !== 8'd1 || bus.frame_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_fill got cnt=%0d valid=%0b want 1 0", bus.sym_count, bus.frame_valid);
        end
        send(14'h0022, 1'b1);
        checks++;
        if (bus.frame_valid !== 1'b1 || bus.frame_out !== {7'h11, 7'h22, 1009'd0}) begin
            errors++; $display("FAIL b2b_close got valid=%0b want 1", bus.frame_valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.frame_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.sym_count !== 8'd0) begin
            errors++; $display("FAIL b2b_hold_one got valid=%0b rdy=%0b cnt=%0d want 0 1 0",
                               bus.frame_valid, bus.in_ready, bus.sym_count);
        end
        send(14'h0033, 1'b1);
        checks++;
        if (bus.frame_valid !== 1'b1 || bus.frame_out !== {7'h33, 1016'd0}) begin
            errors++; $display("FAIL b2b_second got valid=%0b top=%h want 1 33",
                               bus.frame_valid, bus.frame_out[1022:1016]);
        end
        @(posedge clk);
        #1;
        bus.frame_ready = 1'b0;
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        rst             = 1'b1;
        bus.mode        = 1'b0;
        bus.in_valid    = 1'b0;
        bus.in_data     = 14'd0;
        bus.in_last     = 1'b0;
        bus.frame_ready = 1'b0;
        test_reset();
        test_encrypt();
        test_capacity();
        test_decrypt();
        test_backpressure();
        test_mode_change();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
